// File: rtl/ssb_tx_sample_sequencer_if.sv
// Sample stream into the SSB TX sequencer. Each word is {amp_field[17:0], delta_phase[13:0]}.
interface ssb_tx_sample_sequencer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ssb_tx_sample_sequencer.sv
// Buffers {amplitude, delta_phase} samples and releases one per audio sample period to the
// SSB H-bridge modulator, with a linear amplitude ramp on key-up, key-down and underrun.
module ssb_tx_sample_sequencer #(
    parameter int unsigned SAMPLE_DIV = 8192,
    parameter int unsigned FIFO_LOG2  = 4,
    parameter int unsigned RAMP_LOG2  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    ssb_tx_sample_sequencer_if.slave s_axis,
    input  logic                     tx_en,
    output logic [13:0]              delta_phase,
    output logic [26:0]              amplitude,
    output logic                     stdby,
    output logic                     tx_active,
    output logic [15:0]              underrun_count,
    output logic [FIFO_LOG2:0]       fifo_level
);
    localparam int unsigned         DEPTH     = 1 << FIFO_LOG2;
    localparam int unsigned         DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE   = DIV_W'(1);
    localparam logic [FIFO_LOG2:0]  FIFO_FULL = {1'b1, {FIFO_LOG2{1'b0}}};
    localparam logic [FIFO_LOG2:0]  LEVEL_ONE = (FIFO_LOG2 + 1)'(1);
    localparam logic [RAMP_LOG2:0]  RAMP_FULL = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic [RAMP_LOG2:0]  RAMP_ONE  = (RAMP_LOG2 + 1)'(1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RAMP_UP   = 2'd1;
    localparam logic [1:0] ACTIVE    = 2'd2;
    localparam logic [1:0] RAMP_DOWN = 2'd3;

    logic [DIV_W-1:0]     div_cnt;
    logic                 strobe;
    logic [31:0]          mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [31:0]          head;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [1:0]           state;
    logic [1:0]           nxt_state;
    logic [RAMP_LOG2:0]   ramp;
    logic [RAMP_LOG2:0]   nxt_ramp;
    logic [17:0]          amp_field;
    logic [17:0]          nxt_amp_field;
    logic [13:0]          sample_dp;
    logic [13:0]          nxt_sample_dp;
    logic                 under_inc;
    logic [26:0]          prod;

    assign strobe        = (div_cnt == DIV_LAST);
    assign s_axis.tready = (fifo_level < FIFO_FULL);
    assign push          = s_axis.tvalid && s_axis.tready;
    assign fifo_empty    = (fifo_level == '0);
    assign head          = mem[rd_ptr];
    assign tx_active     = (state != IDLE);

    // Pop decisions look only at the occupancy before this cycle's write.
    always_comb begin
        nxt_state     = state;
        nxt_ramp      = ramp;
        nxt_amp_field = amp_field;
        nxt_sample_dp = sample_dp;
        pop           = 1'b0;
        under_inc     = 1'b0;
        if (strobe) begin
            case (state)
                IDLE: begin
                    if (tx_en && !fifo_empty) begin
                        pop       = 1'b1;
                        nxt_ramp  = RAMP_ONE;
                        nxt_state = RAMP_UP;
                    end
                end
                RAMP_UP, ACTIVE: begin
                    if (!tx_en || fifo_empty) begin
                        under_inc = tx_en;
                        nxt_ramp  = ramp - RAMP_ONE;
                        nxt_state = (ramp == RAMP_ONE) ? IDLE : RAMP_DOWN;
                    end else begin
                        pop = 1'b1;
                        if (ramp != RAMP_FULL) nxt_ramp = ramp + RAMP_ONE;
                        nxt_state = (nxt_ramp == RAMP_FULL) ? ACTIVE : RAMP_UP;
                    end
                end
                default: begin
                    if (ramp != '0) nxt_ramp = ramp - RAMP_ONE;
                    if (ramp <= RAMP_ONE) nxt_state = IDLE;
                end
            endcase
            if (pop) begin
                nxt_amp_field = head[31:14];
                nxt_sample_dp = head[13:0];
            end
        end
    end

    assign prod = {5'b0, nxt_amp_field, 4'b0} * 27'(nxt_ramp);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_axis.tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            state          <= IDLE;
            ramp           <= '0;
            amp_field      <= '0;
            sample_dp      <= '0;
            underrun_count <= '0;
            amplitude      <= '0;
            delta_phase    <= '0;
            stdby          <= 1'b1;
        end else begin
            div_cnt   <= strobe ? '0 : div_cnt + DIV_ONE;
            state     <= nxt_state;
            ramp      <= nxt_ramp;
            amp_field <= nxt_amp_field;
            sample_dp <= nxt_sample_dp;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
                2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            if (under_inc && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
            if (nxt_state == IDLE) begin
                amplitude   <= '0;
                delta_phase <= '0;
                stdby       <= 1'b1;
            end else begin
                amplitude   <= prod >> RAMP_LOG2;
                delta_phase <= nxt_sample_dp;
                stdby       <= 1'b0;
            end
        end
    end
endmodule
